// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM controller: command encodings, arbiter
// state encodings and bus widths.
package sdram_pkg;

    localparam int ADDR_W = 12;
    localparam int BANK_W = 2;

    typedef logic [3:0]        sdram_cmd_t;
    typedef logic [ADDR_W-1:0] sdram_addr_t;
    typedef logic [BANK_W-1:0] sdram_bank_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam sdram_cmd_t CMD_NOP     = 4'b0111;
    localparam sdram_cmd_t CMD_PRECHAR = 4'b0010;
    localparam sdram_cmd_t CMD_AREF    = 4'b0001;
    localparam sdram_cmd_t CMD_ACTIVE  = 4'b0011;
    localparam sdram_cmd_t CMD_WRITE   = 4'b0100;
    localparam sdram_cmd_t CMD_READ    = 4'b0101;
    localparam sdram_cmd_t CMD_MRS     = 4'b0000;

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_ARBIT = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    function automatic logic is_grant(input logic [2:0] st);
        return (st == S_AREF) || (st == S_WRITE) || (st == S_READ);
    endfunction

endpackage

// File: rtl/sdram_arbit.sv
// Central SDRAM bus sequencer: holds the pins for the init engine, then
// time-shares the command/address bus between refresh, write and read engines.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int         MAX_BUSY = 1023,
    parameter sdram_cmd_t NOP      = CMD_NOP
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              req_aref,
    input  logic              end_aref,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              req_wr,
    input  logic              end_wr,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic              req_rd,
    input  logic              end_rd,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              en_aref,
    output logic              en_wr,
    output logic              en_rd,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(MAX_BUSY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BUSY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BUSY);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt_busy;
    logic             last_wr;
    logic             end_cur;
    logic             timeout;
    logic             in_grant;

    assign in_grant = is_grant(state);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        end_cur = 1'b0;
        case (state)
            S_AREF:  end_cur = end_aref;
            S_WRITE: end_cur = end_wr;
            S_READ:  end_cur = end_rd;
            default: end_cur = 1'b0;
        endcase
    end

    // A completion in the same cycle as the watchdog limit takes precedence.
    assign timeout = in_grant && (cnt_busy == CNT_LAST) && !end_cur;

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: begin
                if (flag_init_end)
                    state_nxt = S_ARBIT;
            end
            S_ARBIT: begin
                if (req_aref)
                    state_nxt = S_AREF;
                else if (req_wr && req_rd)
                    state_nxt = last_wr ? S_READ : S_WRITE;
                else if (req_wr)
                    state_nxt = S_WRITE;
                else if (req_rd)
                    state_nxt = S_READ;
            end
            S_AREF, S_WRITE, S_READ: begin
                if (end_cur || timeout)
                    state_nxt = S_ARBIT;
            end
            default: state_nxt = flag_init_end ? S_ARBIT : S_INIT;
        endcase
    end

    // Grants are registered together with the state so en_x tracks state == X exactly.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state       <= S_INIT;
            en_aref     <= 1'b0;
            en_wr       <= 1'b0;
            en_rd       <= 1'b0;
            sdram_cke   <= 1'b0;
            err_timeout <= 1'b0;
            last_wr     <= 1'b0;
            cnt_busy    <= '0;
        end else begin
            state     <= state_nxt;
            en_aref   <= (state_nxt == S_AREF);
            en_wr     <= (state_nxt == S_WRITE);
            en_rd     <= (state_nxt == S_READ);
            sdram_cke <= 1'b1;

            if (state == S_ARBIT && state_nxt == S_WRITE)
                last_wr <= 1'b1;
            else if (state == S_ARBIT && state_nxt == S_READ)
                last_wr <= 1'b0;

            if (timeout)
                err_timeout <= 1'b1;

            if (!in_grant)
                cnt_busy <= '0;
            else if (cnt_busy != CNT_MAX)
                cnt_busy <= cnt_busy + 1'b1;
        end
    end

    // Engines register their own outputs, so the pin mux is purely combinational.
    always_comb begin
        sdram_cmd  = NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: sdram_cmd = NOP;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: a per-cycle behavioural model of bus
// ownership plus literal expectations for each scenario.
module tb_sdram_arbit;

    localparam int MAX_B = 16;

    logic        s_clk = 1'b0;
    logic        s_rst_n = 1'b1;
    logic        flag_init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        req_aref, end_aref;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;
    logic        req_wr, end_wr;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        req_rd, end_rd;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        en_aref, en_wr, en_rd;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic        err_timeout;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_on = 0;

    sdram_arbit #(.MAX_BUSY(MAX_B)) dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .req_aref(req_aref), .end_aref(end_aref), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .req_wr(req_wr), .end_wr(end_wr), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .req_rd(req_rd), .end_rd(end_rd), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .en_aref(en_aref), .en_wr(en_wr), .en_rd(en_rd), .sdram_cke(sdram_cke),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
        .err_timeout(err_timeout)
    );

    always #5 s_clk = ~s_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 none, 1 refresh, 2 write, 3 read) and for how long.
    typedef struct packed {
        logic        in_init;
        logic [1:0]  owner;
        logic [15:0] age;
        logic        last_wr;
        logic        err;
        logic        cke;
    } mdl_t;

    localparam mdl_t MDL_RST = '{in_init: 1'b1, owner: 2'd0, age: 16'd0,
                                 last_wr: 1'b0, err: 1'b0, cke: 1'b0};
    mdl_t m;

    function automatic logic owner_done(input logic [1:0] o);
        return (o == 2'd1 && end_aref) || (o == 2'd2 && end_wr) || (o == 2'd3 && end_rd);
    endfunction

    function automatic mdl_t mdl_next(input mdl_t s);
        mdl_t n = s;
        n.cke = 1'b1;
        if (s.in_init) begin
            if (flag_init_end) n.in_init = 1'b0;
        end else if (s.owner == 2'd0) begin
            n.age = 16'd0;
            // refresh first; a write wins unless a read also waits and a write went last
            if (req_aref)                         n.owner = 2'd1;
            else if (req_wr && (!req_rd || !s.last_wr)) n.owner = 2'd2;
            else if (req_rd)                      n.owner = 2'd3;
            if (n.owner == 2'd2) n.last_wr = 1'b1;
            if (n.owner == 2'd3) n.last_wr = 1'b0;
        end else begin
            n.age = s.age + 16'd1;
            if (owner_done(s.owner)) n.owner = 2'd0;
            else if (n.age == 16'(MAX_B)) begin
                n.owner = 2'd0;
                n.err   = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [18:0] exp_pins(input mdl_t s);
        logic [3:0]  c;
        logic [11:0] a;
        logic [1:0]  b;
        c = 4'b0111; a = 12'd0; b = 2'd0;
        if (s.in_init) begin
            c = init_cmd; a = init_addr;
        end else begin
            case (s.owner)
                2'd1: begin c = aref_cmd; a = aref_addr; end
                2'd2: begin c = wr_cmd; a = wr_addr; b = wr_bank; end
                2'd3: begin c = rd_cmd; a = rd_addr; b = rd_bank; end
                default: ;
            endcase
        end
        return {s.cke, c, a, b};
    endfunction

    always @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) m <= MDL_RST;
        else          m <= mdl_next(m);
    end

    always @(negedge s_clk) begin
        if (cmp_on) begin
            check("cyc_en", {29'd0, en_aref, en_wr, en_rd},
                  {29'd0, m.owner == 2'd1, m.owner == 2'd2, m.owner == 2'd3});
            check("cyc_pins", {13'd0, sdram_cke, sdram_cmd, sdram_addr, sdram_bank},
                  {13'd0, exp_pins(m)});
            check("cyc_err", {31'd0, err_timeout}, {31'd0, m.err});
        end
    end

    // Engine emulation: record grant order and lengths, end each grant after 'hold' cycles.
    int q_order[$];
    int q_len[$];
    int age;
    bit prev_en;
    bit keep_wr;
    bit rereq_rd;

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic step(input int hold);
        logic any_en;
        any_en = en_aref | en_wr | en_rd;
        end_aref = 1'b0; end_wr = 1'b0; end_rd = 1'b0;
        if (any_en) begin
            if (!prev_en) begin
                q_order.push_back(en_aref ? 1 : (en_wr ? 2 : 3));
                age = 0;
            end
            age++;
            if (en_aref) req_aref = 1'b0;
            if (en_wr && !keep_wr) req_wr = 1'b0;
            if (en_rd) req_rd = 1'b0;
            if (hold != 0 && age == hold) begin
                end_aref = en_aref; end_wr = en_wr; end_rd = en_rd;
            end
        end else if (prev_en) begin
            q_len.push_back(age);
        end
        if (rereq_rd && !en_rd) req_rd = 1'b1;
        prev_en = any_en;
    endtask

    task automatic run_grants(input int hold, input bit kw, input bit rr, input int n, input int budget);
        keep_wr = kw; rereq_rd = rr; prev_en = 1'b0;
        q_order.delete(); q_len.delete();
        for (int c = 0; c < budget; c++) begin
            tick();
            step(hold);
            if (q_order.size() >= n) begin
                keep_wr = 1'b0; rereq_rd = 1'b0;
                req_aref = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
                if (!prev_en && q_len.size() == q_order.size()) return;
            end
        end
        check("grant_budget", 32'(q_order.size()), 32'(n));
    endtask

    function automatic int q_at(input int i, input bit lens);
        if (lens) return (i < q_len.size()) ? q_len[i] : -1;
        return (i < q_order.size()) ? q_order[i] : -1;
    endfunction

    initial begin
        flag_init_end = 1'b0;
        init_cmd = 4'b0010; init_addr = 12'h400;
        req_aref = 1'b0; end_aref = 1'b0; aref_cmd = 4'b0001; aref_addr = 12'h555;
        req_wr = 1'b0; end_wr = 1'b0; wr_cmd = 4'b0100; wr_addr = 12'h123; wr_bank = 2'b10;
        req_rd = 1'b0; end_rd = 1'b0; rd_cmd = 4'b0101; rd_addr = 12'h0ab; rd_bank = 2'b01;
        keep_wr = 1'b0; rereq_rd = 1'b0; prev_en = 1'b0; age = 0;

        #2 s_rst_n = 1'b0;
        cmp_on = 1'b1;
        #1;
        check("rst_cke", {31'd0, sdram_cke}, 32'd0);
        check("rst_en", {29'd0, en_aref, en_wr, en_rd}, 32'd0);
        check("rst_cmd", {28'd0, sdram_cmd}, 32'h2);
        #20 s_rst_n = 1'b1;

        // 1: init phase holds the bus
        repeat (50) tick();
        check("init_cmd", {28'd0, sdram_cmd}, 32'h2);
        check("init_addr", {20'd0, sdram_addr}, 32'h400);
        check("init_en", {29'd0, en_aref, en_wr, en_rd}, 32'd0);
        check("init_cke", {31'd0, sdram_cke}, 32'd1);
        flag_init_end = 1'b1;
        tick();
        check("arbit_nop", {28'd0, sdram_cmd}, 32'h7);

        // 2: single refresh, end pulsed on its fifth cycle
        req_aref = 1'b1;
        run_grants(5, 1'b0, 1'b0, 1, 40);
        check("aref_who", 32'(q_at(0, 1'b0)), 32'd1);
        check("aref_len", 32'(q_at(0, 1'b1)), 32'd5);
        check("aref_after_nop", {28'd0, sdram_cmd}, 32'h7);

        // 3: simultaneous requests, then lone write followed by wr+rd together
        req_aref = 1'b1; req_wr = 1'b1; req_rd = 1'b1;
        run_grants(3, 1'b0, 1'b0, 3, 80);
        check("all3_first", 32'(q_at(0, 1'b0)), 32'd1);
        check("all3_second", 32'(q_at(1, 1'b0)), 32'd2);
        check("all3_third", 32'(q_at(2, 1'b0)), 32'd3);
        req_wr = 1'b1;
        run_grants(2, 1'b0, 1'b0, 1, 40);
        req_wr = 1'b1; req_rd = 1'b1;
        run_grants(2, 1'b0, 1'b0, 2, 60);
        check("wrrd_first", 32'(q_at(0, 1'b0)), 32'd3);
        check("wrrd_second", 32'(q_at(1, 1'b0)), 32'd2);

        // 4: write held permanently, read re-requested after each service
        req_wr = 1'b1;
        run_grants(3, 1'b1, 1'b1, 6, 120);
        for (int i = 1; i < 6; i++)
            check("alternate", {31'd0, q_at(i, 1'b0) != q_at(i - 1, 1'b0)}, 32'd1);

        // 5: end on the last allowed cycle is not a timeout; missing end is
        req_wr = 1'b1;
        run_grants(MAX_B, 1'b0, 1'b0, 1, 60);
        check("wd_edge_len", 32'(q_at(0, 1'b1)), 32'd16);
        check("wd_edge_err", {31'd0, err_timeout}, 32'd0);
        req_wr = 1'b1;
        run_grants(0, 1'b0, 1'b0, 1, 60);
        check("wd_len", 32'(q_at(0, 1'b1)), 32'd16);
        check("wd_err", {31'd0, err_timeout}, 32'd1);
        repeat (5) tick();
        check("wd_sticky", {31'd0, err_timeout}, 32'd1);

        // 6: asynchronous reset in the middle of a read grant
        req_rd = 1'b1;
        for (int c = 0; c < 10 && !en_rd; c++) tick();
        check("rd_granted", {31'd0, en_rd}, 32'd1);
        req_rd = 1'b0;
        tick();
        #2 s_rst_n = 1'b0;
        #1;
        check("arst_en_rd", {31'd0, en_rd}, 32'd0);
        check("arst_cke", {31'd0, sdram_cke}, 32'd0);
        check("arst_cmd", {28'd0, sdram_cmd}, 32'h2);
        check("arst_err", {31'd0, err_timeout}, 32'd0);
        #14 s_rst_n = 1'b1;
        tick();
        check("post_rst_cmd", {28'd0, sdram_cmd}, 32'h7);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: got still running expected finished");
        $fatal(1);
    end

endmodule
